uart_tx_fifo: RTL

Parametrised successor to the single-byte UART transmitter. It serialises words onto one TX line with configurable data width, optional even/odd parity and 1 or 2 stop bits. A small internal FIFO lets the CPU bus queue several characters without polling between them. The block sits between the memory-mapped I/O write path (write_data/write_enable) and the board TX pin.

---
 rtl/uart_tx_fifo_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/uart_tx_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
//   Shared definitions for the buffered UART transmitter: FSM state
//   encodings, parity_mode codes, idle line level and a parity helper.
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  localparam logic LINE_IDLE = 1'b1;

  // Mode 11 is reserved and behaves like "none".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO, power-of-two depth, registered full/empty.
//   Ports:
//     clk, rst_n   clock, async active-low reset (clears pointers/count)
//     i_push       write request, ignored while full
//     i_pop        read request, ignored while empty
//     i_wdata      word to write
//     o_rdata      head word (combinational read of the head slot)
//     o_full       registered, count == DEPTH
//     o_empty      registered, count == 0
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count, w_count_nx;
  logic             r_full, r_empty;
  logic             w_do_push, w_do_pop;

  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop  && !r_empty;

  always_comb begin
    w_count_nx = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nx = r_count + 1'b1;
      2'b01:   w_count_nx = r_count - 1'b1;
      default: w_count_nx = r_count;
    endcase
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nx;
      r_full  <= (w_count_nx == CW'(DEPTH));
      r_empty <= (w_count_nx == '0);
    end
  end

  // Storage needs no reset: empty/pointers gate every read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered UART transmitter: a sync_fifo queues words from the bus write
//   path, an FSM serialises them as start / DATA_BITS data (LSB first) /
//   optional parity / 1 or 2 stop bits. Each line bit lasts P clocks where
//   P = max(cycles,1), latched together with parity/stop config at frame start.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     cycles              bit period in clocks (0 treated as 1)
//     parity_mode         00/11 none, 01 even, 10 odd
//     two_stop            1 = two stop bits
//     write_data/_enable  push port, one word per cycle
//     full, empty         FIFO status (registered)
//     busy                frame on the line
//     overflow            one-cycle pulse for a push while full
//     tx_line             registered serial output, idle high
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CYCLES_W   = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CYCLES_W-1:0] cycles,
  input  logic [1:0]          parity_mode,
  input  logic                two_stop,
  input  logic [7:0]          write_data,
  input  logic                write_enable,
  output logic                full,
  output logic                empty,
  output logic                busy,
  output logic                overflow,
  output logic                tx_line
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  logic                 w_full, w_empty, w_pop, w_load, w_bit_end;
  logic [DATA_BITS-1:0] w_fifo_dout;

  tx_state_e            r_state, w_state_nx;
  logic [CYCLES_W-1:0]  r_cnt, w_cnt_nx;
  logic [CYCLES_W-1:0]  r_period, w_period_nx;
  logic [IDX_W-1:0]     r_idx, w_idx_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                 r_par_en, w_par_en_nx;
  logic                 r_par_bit, w_par_bit_nx;
  logic                 r_two_stop, w_two_stop_nx;
  logic                 r_stop2, w_stop2_nx;
  logic                 r_tx, w_tx_nx;
  logic                 r_overflow;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (write_enable),
    .i_pop   (w_pop),
    .i_wdata (write_data[DATA_BITS-1:0]),
    .o_rdata (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_bit_end = (r_cnt == r_period - 1'b1);

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt + 1'b1;
    w_period_nx   = r_period;
    w_idx_nx      = r_idx;
    w_shift_nx    = r_shift;
    w_par_en_nx   = r_par_en;
    w_par_bit_nx  = r_par_bit;
    w_two_stop_nx = r_two_stop;
    w_stop2_nx    = r_stop2;
    w_tx_nx       = r_tx;
    w_load        = 1'b0;
    w_pop         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        w_tx_nx  = LINE_IDLE;
        if (!w_empty) w_load = 1'b1;
      end
      ST_START: begin
        if (w_bit_end) begin
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
          w_tx_nx    = r_shift[0];
          w_state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_nx = '0;
          if (r_idx == IDX_W'(DATA_BITS - 1)) begin
            w_stop2_nx = 1'b0;
            if (r_par_en) begin
              w_tx_nx    = r_par_bit;
              w_state_nx = ST_PARITY;
            end else begin
              w_tx_nx    = LINE_IDLE;
              w_state_nx = ST_STOP;
            end
          end else begin
            w_shift_nx = r_shift >> 1;
            w_tx_nx    = r_shift[1];
            w_idx_nx   = r_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_cnt_nx   = '0;
          w_tx_nx    = LINE_IDLE;
          w_state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_cnt_nx = '0;
          if (r_two_stop && !r_stop2) begin
            w_stop2_nx = 1'b1;
          end else if (!w_empty) begin
            w_load = 1'b1;                // back-to-back, no idle cycle
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_tx_nx    = LINE_IDLE;
      end
    endcase

    // Frame start: pop head and freeze the config for the whole frame.
    if (w_load) begin
      w_pop         = 1'b1;
      w_state_nx    = ST_START;
      w_tx_nx       = 1'b0;
      w_cnt_nx      = '0;
      w_shift_nx    = w_fifo_dout;
      w_period_nx   = (cycles == '0) ? CYCLES_W'(1) : cycles;
      w_par_en_nx   = parity_enabled(parity_mode);
      w_par_bit_nx  = (^w_fifo_dout) ^ (parity_mode == PARITY_ODD);
      w_two_stop_nx = two_stop;
      w_stop2_nx    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_period   <= CYCLES_W'(1);
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop2    <= 1'b0;
      r_tx       <= LINE_IDLE;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_period   <= w_period_nx;
      r_idx      <= w_idx_nx;
      r_shift    <= w_shift_nx;
      r_par_en   <= w_par_en_nx;
      r_par_bit  <= w_par_bit_nx;
      r_two_stop <= w_two_stop_nx;
      r_stop2    <= w_stop2_nx;
      r_tx       <= w_tx_nx;
      r_overflow <= write_enable && w_full;
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign busy     = (r_state != ST_IDLE);
  assign overflow = r_overflow;
  assign tx_line  = r_tx;

endmodule
